hls_test2_sched: RTL

- Resource-constrained, FSM-scheduled implementation of the test2 dataflow:
  - d=a+b, e=a+c, f=a-b
  - g=min-select(d,e), h=eq-select(g,f)
  - x=g<<dLTe, z=h>>dEQe
- Successor to the fully-pipelined test2 model. Adds:
  - parameterised width
  - Start/Done/Busy handshake with input capture
  - a single shared add/sub unit and a single comparator
- Serves as the synthesis-target reference against which HLS-generated test2 netlists are checked in the tb flow.

---
 rtl/hls_test2_pkg.sv | 23 ++
 rtl/hls_test2_sched_if.sv | 18 +
 rtl/hls_addsub.sv | 15 +
 rtl/hls_test2_sched.sv | 121 ++++++++++++
 4 files changed

// File: rtl/hls_test2_pkg.sv
// Shared encodings for the scheduled test2 dataflow: FSM states, ALU modes
// and the fixed Start-to-Done latency.
package hls_test2_pkg;

   localparam int LATENCY = 7;

   typedef enum logic [2:0] {
      WAIT  = 3'd0,
      S1    = 3'd1,
      S2    = 3'd2,
      S3    = 3'd3,
      S4    = 3'd4,
      S5    = 3'd5,
      S6    = 3'd6,
      FINAL = 3'd7
   } state_e;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_mode_e;

endpackage

// File: rtl/hls_test2_sched_if.sv
// Start/Done/Busy handshake plus operand and result buses of the test2 scheduler.
interface hls_test2_sched_if #(
   parameter int DATAWIDTH = 32
);

   logic                 Start;
   logic [DATAWIDTH-1:0] a;
   logic [DATAWIDTH-1:0] b;
   logic [DATAWIDTH-1:0] c;
   logic                 Busy;
   logic                 Done;
   logic [DATAWIDTH-1:0] x;
   logic [DATAWIDTH-1:0] z;

   modport master (output Start, a, b, c, input Busy, Done, x, z);
   modport slave  (input Start, a, b, c, output Busy, Done, x, z);

endinterface

// File: rtl/hls_addsub.sv
// Combinational wrapping adder/subtractor shared by every arithmetic step.
module hls_addsub
   import hls_test2_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] op_a,
   input  logic [DATAWIDTH-1:0] op_b,
   input  alu_mode_e            mode,
   output logic [DATAWIDTH-1:0] result
);

   assign result = (mode == ALU_SUB) ? op_a - op_b : op_a + op_b;

endmodule

// File: rtl/hls_test2_sched.sv
// Resource-constrained test2: one add/sub unit and one comparator, time-shared
// over six FSM steps, with captured inputs and a one-cycle Done pulse.
module hls_test2_sched
   import hls_test2_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input logic              Clk,
   input logic              Rst,
   hls_test2_sched_if.slave bus
);

   state_e               state;
   logic [DATAWIDTH-1:0] ra, rb, rc;
   logic [DATAWIDTH-1:0] d, e, f, g, h;
   logic [DATAWIDTH-1:0] x, z;
   logic                 d_lt_e, d_eq_e;
   logic                 busy, done;

   logic [DATAWIDTH-1:0] alu_b, alu_y;
   alu_mode_e            alu_mode;
   logic                 cmp_lt, cmp_eq;

   // Operand A is always ra; only B and the mode change per step.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      alu_b    = rb;
      alu_mode = ALU_ADD;
      if (state == S2) alu_b = rc;
      if (state == S3) alu_mode = ALU_SUB;
   end

   hls_addsub #(.DATAWIDTH(DATAWIDTH)) u_addsub (
      .op_a   (ra),
      .op_b   (alu_b),
      .mode   (alu_mode),
      .result (alu_y)
   );

   // The comparison sees the wrapped sums, interpreted as signed.
   assign cmp_lt = $signed(d) < $signed(e);
   assign cmp_eq = (d == e);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, matching the hardware.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= WAIT;
         busy   <= 1'b0;
         done   <= 1'b0;
         ra     <= '0;
         rb     <= '0;
         rc     <= '0;
         d      <= '0;
         e      <= '0;
         f      <= '0;
         g      <= '0;
         h      <= '0;
         x      <= '0;
         z      <= '0;
         d_lt_e <= 1'b0;
         d_eq_e <= 1'b0;
      end else begin
         case (state)
            WAIT: begin
               if (bus.Start) begin
                  ra    <= bus.a;
                  rb    <= bus.b;
                  rc    <= bus.c;
                  busy  <= 1'b1;
                  state <= S1;
               end
            end
            S1: begin
               d     <= alu_y;
               state <= S2;
            end
            S2: begin
               e     <= alu_y;
               state <= S3;
            end
            S3: begin
               f      <= alu_y;
               d_lt_e <= cmp_lt;
               d_eq_e <= cmp_eq;
               state  <= S4;
            end
            S4: begin
               g     <= d_lt_e ? d : e;
               state <= S5;
            end
            S5: begin
               h     <= d_eq_e ? g : f;
               x     <= g << d_lt_e;
               state <= S6;
            end
            S6: begin
               z     <= h >> d_eq_e;
               done  <= 1'b1;
               state <= FINAL;
            end
            FINAL: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= WAIT;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= WAIT;
            end
         endcase
      end
   end

   assign bus.Busy = busy;
   assign bus.Done = done;
   assign bus.x    = x;
   assign bus.z    = z;

endmodule
